// File: rtl/mux16_arbiter.sv
// Two-requester round-robin arbiter steering a 16-bit Mux16 onto one valid/ready channel.
// Define MUX16_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST accepted beats.
module mux16_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_a,
  input  logic             last_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   sel_q, sel_d;
  logic   fire;
  logic   cur_req, cur_last, other_req;
  logic   grant_end;
  logic   cnt_hit;

`ifdef MUX16_ARB_BURST_LIMIT_EN
  localparam int unsigned     CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The beat being accepted now is the MAX_BURST-th of this grant.
  assign cnt_hit = (cnt_q == CntMax - CntW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (grant_end) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign cnt_hit = 1'b0;
`endif

  assign gnt_a     = (state_q == StGrantA);
  assign gnt_b     = (state_q == StGrantB);
  assign sel       = sel_q;
  assign busy      = (state_q != StIdle);
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign fire      = out_valid & out_ready;
  assign out_data  = sel_q ? data_b : data_a;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    sel_d     = sel_q;
    grant_end = 1'b0;
    cur_req   = (state_q == StGrantB) ? req_b  : req_a;
    cur_last  = (state_q == StGrantB) ? last_b : last_a;
    other_req = (state_q == StGrantB) ? req_a  : req_b;

    unique case (state_q)
      StIdle: begin
        if (req_a && (!req_b || !prio_q)) begin
          state_d = StGrantA;
        end else if (req_b) begin
          state_d = StGrantB;
        end
      end
      StGrantA, StGrantB: begin
        // Withdrawal, a last beat, or the burst cap closes the grant; one event per grant.
        grant_end = !cur_req || (fire && (cur_last || cnt_hit));
      end
      default: state_d = StIdle;
    endcase

    if (grant_end) begin
      prio_d = (state_q == StGrantA);
      if (other_req) begin
        state_d = (state_q == StGrantA) ? StGrantB : StGrantA;
      end else begin
        state_d = StIdle;
      end
    end

    if (state_d == StGrantA) begin
      sel_d = 1'b0;
    end else if (state_d == StGrantB) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Scoreboard bench for mux16_arbiter: producers feed beat queues, accepted beats are
// compared in order against the arbitration sequence the bench predicts.
module tb_mux16_arbiter;

  localparam int unsigned Width = 16;

  typedef struct packed {
    logic             last;
    logic [Width-1:0] data;
  } beat_t;

  typedef struct packed {
    logic             sel;
    logic [Width-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_a, req_b;
  logic [Width-1:0] data_a, data_b;
  logic             last_a, last_b;
  logic             gnt_a, gnt_b, sel, out_valid, busy;
  logic [Width-1:0] out_data;
  logic             out_ready;

  beat_t qa[$];
  beat_t qb[$];
  exp_t  sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [Width-1:0] IdleA = 16'h1234;
  localparam logic [Width-1:0] IdleB = 16'hABCD;

  mux16_arbiter #(
    .WIDTH    (Width),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .last_a   (last_a),
    .last_b   (last_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic s, input logic [Width-1:0] d);
    exp_t e;
    e.sel  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_a(input logic [Width-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    qa.push_back(b);
  endtask

  task automatic push_b(input logic [Width-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    qb.push_back(b);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    qa.delete();
    qb.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || busy) && n < 60) begin
      tick();
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(n < 60), 1);
    check_eq({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // Producers: hold the head beat until an accept is seen, then advance.
  initial begin : producers
    bit fa, fb;
    forever begin
      @(negedge clk);
      fa = gnt_a & req_a & out_ready;
      fb = gnt_b & req_b & out_ready;
      @(posedge clk);
      #2;
      if (fa && qa.size() != 0) void'(qa.pop_front());
      if (fb && qb.size() != 0) void'(qb.pop_front());
      req_a  = (qa.size() != 0);
      req_b  = (qb.size() != 0);
      data_a = req_a ? qa[0].data : IdleA;
      last_a = req_a ? qa[0].last : 1'b0;
      data_b = req_b ? qb[0].data : IdleB;
      last_b = req_b ? qb[0].last : 1'b0;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_beat", {15'd0, sel, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check_eq("beat_data", out_data, e.data);
          check_eq("beat_sel", sel, e.sel);
        end
      end
    end
  end

  initial begin : main
    reset     = 1'b1;
    req_a     = 1'b0;
    req_b     = 1'b0;
    data_a    = IdleA;
    data_b    = IdleB;
    last_a    = 1'b0;
    last_b    = 1'b0;
    out_ready = 1'b1;
    do_reset();

    check_eq("rst_gnt_a", gnt_a, 0);
    check_eq("rst_gnt_b", gnt_b, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, IdleA);

    // Single beat from A.
    push_a(16'd3567, 1'b1);
    expect_beat(1'b0, 16'd3567);
    tick();
    check_eq("a1_gnt_a", gnt_a, 1);
    check_eq("a1_valid", out_valid, 1);
    check_eq("a1_data", out_data, 16'd3567);
    tick();
    check_eq("a1_released", gnt_a, 0);
    check_eq("a1_busy", busy, 0);
    wait_idle("a1");

    // Simultaneous single-beat requests: A first, B with zero bubble, twice.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_a(16'd3567, 1'b1);
      push_b(16'd1095, 1'b1);
      expect_beat(1'b0, 16'd3567);
      expect_beat(1'b1, 16'd1095);
      tick();
      check_eq("sim_first_a", gnt_a, 1);
      check_eq("sim_first_sel", sel, 0);
      tick();
      check_eq("sim_handover_b", gnt_b, 1);
      check_eq("sim_handover_sel", sel, 1);
      check_eq("sim_handover_data", out_data, 16'd1095);
      wait_idle("sim");
    end

    // B stalled by the consumer for three cycles.
    out_ready = 1'b0;
    push_b(16'h8DEF, 1'b1);
    expect_beat(1'b1, 16'h8DEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_gnt_b", gnt_b, 1);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, 16'h8DEF);
    end
    out_ready = 1'b1;
    tick();
    check_eq("stall_release", gnt_b, 0);
    wait_idle("stall");

    // A streams six beats while B waits with one beat.
    do_reset();
    for (int i = 0; i < 6; i++) push_a(16'(100 + i), 1'(i == 5));
    push_b(16'd200, 1'b1);
`ifdef MUX16_ARB_BURST_LIMIT_EN
    for (int i = 0; i < 4; i++) expect_beat(1'b0, 16'(100 + i));
    expect_beat(1'b1, 16'd200);
    for (int i = 4; i < 6; i++) expect_beat(1'b0, 16'(100 + i));
    repeat (5) tick();
    check_eq("burst_cap_gnt_b", gnt_b, 1);
    check_eq("burst_cap_sel", sel, 1);
    tick();
    check_eq("burst_regrant_a", gnt_a, 1);
`else
    for (int i = 0; i < 6; i++) expect_beat(1'b0, 16'(100 + i));
    expect_beat(1'b1, 16'd200);
    repeat (5) tick();
    check_eq("burst_hold_gnt_a", gnt_a, 1);
    repeat (2) tick();
    check_eq("burst_after_last_b", gnt_b, 1);
`endif
    wait_idle("burst");

    // Reset in the middle of an A burst.
    do_reset();
    for (int i = 0; i < 4; i++) push_a(16'(300 + i), 1'b0);
    expect_beat(1'b0, 16'd300);
    expect_beat(1'b0, 16'd301);
    repeat (3) tick();
    reset = 1'b1;
    qa.delete();
    req_a = 1'b0;
    #1;
    check_eq("mid_rst_gnt_a", gnt_a, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_sel", sel, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_sb", sb.size(), 0);
    tick();
    reset = 1'b0;
    push_a(16'd11, 1'b1);
    push_b(16'd22, 1'b1);
    expect_beat(1'b0, 16'd11);
    expect_beat(1'b1, 16'd22);
    tick();
    check_eq("post_rst_prio_a", gnt_a, 1);
    wait_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
